// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the bit-serial adder job sequencer.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 4;
    // Cycles from the ISSUE state to the adder's done pulse.
    localparam int ADDER_LATENCY = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } seq_state_e;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand stream, adder control bus and result stream of the sequencer.
interface serial_add_sequencer_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             add_load;
    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_done;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;

    // The sequencer is the slave; the surrounding system (producer, adder, consumer) is the master.
    modport slave (
        input  in_valid, in_a, in_b, add_sum, add_done, out_ready,
        output in_ready, add_load, add_start, add_a, add_b, out_valid, out_sum
    );

    modport master (
        output in_valid, in_a, in_b, add_sum, add_done, out_ready,
        input  in_ready, add_load, add_start, add_a, add_b, out_valid, out_sum
    );

endinterface

// File: rtl/serial_add_sequencer_fifo.sv
// Small synchronous FIFO holding queued operand pairs; head is read without a pop.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Queues operand pairs, runs each through the bit-serial adder and holds its sum for the consumer,
// with a watchdog and sticky error for missing or stray done pulses.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sequencer_if.slave bus,
    output logic [7:0]            jobs_done,
    output logic                  err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int CW   = $clog2(DEPTH) + 1;

    seq_state_e         state;
    logic [WD_W-1:0]    watchdog;
    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic [CW-1:0]      fifo_count;
    logic               slot_free;
    logic               pop;

    sync_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata ({bus.in_a, bus.in_b}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // A job is only started when its result is guaranteed a free slot on arrival.
    assign slot_free     = ~bus.out_valid | bus.out_ready;
    assign pop           = (state == IDLE) & ~empty & slot_free;
    assign bus.in_ready  = ~full;
    assign bus.add_load  = (state == ISSUE);
    assign bus.add_start = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            watchdog      <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            jobs_done     <= '0;
            err           <= 1'b0;
        end else begin
            if (bus.out_valid & bus.out_ready) bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.add_done) err <= 1'b1;
                    if (pop) begin
                        bus.add_a <= head[2*WIDTH-1:WIDTH];
                        bus.add_b <= head[WIDTH-1:0];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.add_done) err <= 1'b1;
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (bus.add_done) begin
                        bus.out_sum   <= bus.add_sum;
                        bus.out_valid <= 1'b1;
                        jobs_done     <= jobs_done + 8'd1;
                        state         <= IDLE;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed scoreboard bench for serial_add_sequencer with a fixed-latency adder model.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] jobs_done;
    logic       err;

    serial_add_sequencer_if #(.WIDTH(4)) bus ();

    serial_add_sequencer #(
        .WIDTH   (4),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .jobs_done (jobs_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         issue_cnt = 0;
    int         last_issue = 0;
    bit         adder_en  = 1'b1;
    logic [3:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] sum, input bit expect_out);
        bit acc;
        bit done = 1'b0;
        int n    = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!done && n < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_accept a=%0d b=%0d not accepted within %0d cycles", a, b, n);
        end else if (expect_out) begin
            exp_q.push_back(sum);
        end
    endtask

    task automatic wait_issue(input string name, output int t);
        bit seen = 1'b0;
        t = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.add_start) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_issue required=issue within 100 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.in_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0d pending required=0 pending", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Adder model: done pulses ADDER_LATENCY cycles after the ISSUE cycle.
    initial begin
        logic [3:0] sa, sb;
        bus.add_done = 1'b0;
        bus.add_sum  = '0;
        forever begin
            @(negedge clk);
            if (bus.add_start && !rst) begin
                issue_cnt++;
                last_issue = cyc;
                sa = bus.add_a;
                sb = bus.add_b;
                if (adder_en) begin
                    repeat (6) @(posedge clk);
                    #1;
                    bus.add_sum  = 4'(sa + sb);
                    bus.add_done = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.add_done = 1'b0;
                end
            end
        end
    end

    initial begin
        bit         hold = 1'b0;
        logic [3:0] held = '0;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_stable", bus.out_sum, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0d required=no output", bus.out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sum", bus.out_sum, e);
                    end
                end
                hold = bus.out_valid && !bus.out_ready;
                held = bus.out_sum;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout actual=cyc%0d required=finish", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int t, c, n0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_add_load", bus.add_load, 0);
        chk("rst_add_start", bus.add_start, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_b", bus.add_b, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_err", err, 0);

        // Single job with exact timing.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push_pair(4'd3, 4'd5, 4'd8, 1'b1);
        wait_issue("single_issue", t);
        chk("single_add_a", bus.add_a, 3);
        chk("single_add_b", bus.add_b, 5);
        chk("single_add_load", bus.add_load, 1);
        @(negedge clk);
        chk("single_start_1cyc", bus.add_start, 0);
        chk("single_load_1cyc", bus.add_load, 0);
        repeat (5) @(negedge clk);
        chk("single_valid_T6", bus.out_valid, 0);
        @(negedge clk);
        chk("single_valid_T7", bus.out_valid, 1);
        chk("single_sum_T7", bus.out_sum, 8);
        chk("single_jobs_done", jobs_done, 1);
        wait_drain("single_drain");

        // Wrap-around sums.
        push_pair(4'd15, 4'd1, 4'd0, 1'b1);
        push_pair(4'd9, 4'd9, 4'd2, 1'b1);
        wait_drain("wrap_drain");
        chk("wrap_err", err, 0);

        // Backpressure and FIFO fill behind an occupied result slot.
        bus.out_ready = 1'b0;
        push_pair(4'd2, 4'd3, 4'd5, 1'b1);
        c = 0;
        while (!bus.out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("bp_first_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        n0 = issue_cnt;
        push_pair(4'd1, 4'd1, 4'd2, 1'b1);
        push_pair(4'd7, 4'd8, 4'd15, 1'b1);
        push_pair(4'd10, 4'd10, 4'd4, 1'b1);
        push_pair(4'd4, 4'd4, 4'd8, 1'b1);
        @(negedge clk);
        chk("fill_in_ready_low", bus.in_ready, 0);
        repeat (20) @(negedge clk);
        chk("bp_no_second_issue", issue_cnt, n0);
        chk("bp_sum_held", bus.out_sum, 5);
        fork
            push_pair(4'd6, 4'd6, 4'd12, 1'b1);
        join_none
        repeat (3) @(negedge clk);
        chk("fill_fifth_blocked", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        c = cyc;
        wait_issue("bp_resume_issue", t);
        chk("bp_issue_cycle", t - c, 1);
        wait_drain("bp_drain");
        chk("bp_jobs_done", jobs_done, 9);

        // Watchdog timeout.
        adder_en = 1'b0;
        push_pair(4'd1, 4'd2, 4'd3, 1'b0);
        wait_issue("to_issue", t);
        repeat (15) @(negedge clk);
        chk("to_err_before", err, 0);
        @(negedge clk);
        chk("to_err_at_timeout", err, 1);
        chk("to_no_output", bus.out_valid, 0);
        chk("to_no_start", bus.add_start, 0);
        adder_en = 1'b1;
        @(posedge clk);
        #1;
        push_pair(4'd5, 4'd6, 4'd11, 1'b1);
        wait_drain("to_next_drain");
        chk("to_err_sticky", err, 1);
        chk("to_jobs_done", jobs_done, 10);

        // Reset two cycles after ISSUE with further jobs queued.
        n0 = issue_cnt;
        push_pair(4'd1, 4'd1, 4'd2, 1'b0);
        push_pair(4'd2, 4'd2, 4'd4, 1'b0);
        push_pair(4'd3, 4'd3, 4'd6, 1'b0);
        chk("rstw_issued", issue_cnt, n0 + 1);
        c = 0;
        while (cyc < last_issue + 2 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_in_ready", bus.in_ready, 1);
        chk("rstw_out_valid", bus.out_valid, 0);
        chk("rstw_out_sum", bus.out_sum, 0);
        chk("rstw_add_load", bus.add_load, 0);
        chk("rstw_add_a", bus.add_a, 0);
        chk("rstw_jobs_done", jobs_done, 0);
        chk("rstw_err", err, 0);
        repeat (4) @(negedge clk);
        chk("rstw_late_done_err", err, 1);
        repeat (8) @(negedge clk);
        chk("rstw_no_output", bus.out_valid, 0);
        chk("rstw_no_reissue", issue_cnt, n0 + 1);
        chk("rstw_jobs_still0", jobs_done, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Upstream job sequencer for the 4-bit bit-serial adder.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Drives the adder's load/start/A/B, waits for its done pulse, then presents each sum on a valid/ready output stream.
- Adds a watchdog and a sticky error flag for a missing or unexpected done.

Parameters:
- WIDTH, 4, operand/sum width; must match the adder.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- TIMEOUT, 15, maximum WAIT cycles without add_done before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO not full
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- add_load  out  1  to adder load
- add_start  out  1  to adder start
- add_a  out  WIDTH  to adder A
- add_b  out  WIDTH  to adder B
- add_sum  in  WIDTH  from adder sum
- add_done  in  1  from adder done, one-cycle pulse
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result, (a+b) mod 2^WIDTH
- jobs_done  out  8  completed-job count, wraps 255→0
- err  out  1  sticky: timeout or unexpected done

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). At integration the adder's rst_n is driven by !rst.
- Reset values: in_ready=1, add_load=0, add_start=0, add_a=0, add_b=0, out_valid=0, out_sum=0, jobs_done=0, err=0, FIFO empty, state IDLE, watchdog=0.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = !full, registered count based.
  - No bypass: a pair accepted in cycle T is issuable at the earliest in T+1.
  - Pop only on the IDLE→ISSUE transition.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop is legal; the count is unchanged.
- Output slot is a single register. slot_free = !out_valid | (out_valid & out_ready).
- States:
  - IDLE: if FIFO non-empty & slot_free, then add_a/add_b <= FIFO head, pop, go to ISSUE.
  - ISSUE (exactly 1 cycle): add_load=add_start=1, decoded from state. Watchdog cleared. Go to WAIT.
  - WAIT: watchdog increments each cycle.
    - If add_done: out_sum <= add_sum, out_valid <= 1, jobs_done++, go to IDLE.
    - Else if watchdog == TIMEOUT-1: err <= 1, job dropped, go to IDLE.
- Adder timing is fixed. With ISSUE in cycle T, add_done is high in T+6. out_valid rises in T+7, when the state is also back in IDLE.
- Best-case throughput is one job per 8 cycles.
- Issuing only when slot_free guarantees the slot is empty when add_done arrives; no result is ever lost.
- out_valid stays high and out_sum holds stable until out_ready is high. It clears on the accepting edge unless a new result loads that same edge.
- add_done seen in IDLE or ISSUE: ignored for data, err <= 1.
- err clears only on rst.
- Reset mid-operation (any state) returns all registers to reset values. FIFO contents and any in-flight job are discarded.

Decomposition:
- Package serial_add_pkg holds:
  - state enum seq_state_e {IDLE, ISSUE, WAIT};
  - localparam ADDER_LATENCY=6 (ISSUE to done);
  - default WIDTH.
- One sub-module: sync_fifo (WIDTH*2 data, DEPTH, push/pop/full/empty/count).
- The sequencer FSM, watchdog and output slot live in the top module.

Test Plan:
- Single job: push a=3, b=5 with out_ready=1 → add_load/add_start high for exactly 1 cycle with add_a=3, add_b=5; out_valid 7 cycles after ISSUE with out_sum=8; jobs_done=1.
- Wrap: push a=15, b=1, then a=9, b=9 → out_sum=0 then 2, in push order; err=0.
- Fill: push 5 pairs back-to-back with the adder model stalled before ISSUE → in_ready low after 4 accepted; fifth accepted only after the first pop; all 5 sums correct and in order.
- Backpressure: out_ready=0 for 20 cycles with 2 jobs queued → first sum held stable and no second ISSUE; after out_ready=1, ISSUE occurs in the accepting cycle's IDLE and the second sum follows.
- Timeout: adder model never asserts done → err=1 exactly TIMEOUT cycles after entering WAIT; state IDLE; next job issues normally; err stays 1.
- Reset mid-WAIT: assert rst 2 cycles after ISSUE with 3 jobs queued → next cycle all outputs at reset values, in_ready=1, jobs_done=0; late add_done pulses after reset set err=1 and produce no output.
